// File: rtl/zlib_pack_pkg.sv
// Shared constants and types for the zlib stream wrapper on the PNG IDAT path.
// The optional stream byte counter is enabled by defining ZLIB_PACK_STAT_EN.
package zlib_pack_pkg;

   localparam logic [7:0] ZLIB_CMF_DEF = 8'h78;
   localparam logic [7:0] ZLIB_FLG_DEF = 8'h01;
   localparam int         BYT_W        = 3;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      BODY     = 3'd1,
      WAIT_ADL = 3'd2,
      TAIL     = 3'd3,
      FIN      = 3'd4
   } state_t;

   // A last-word byte count outside 1..4 means a full word.
   function automatic logic [BYT_W-1:0] fix_byt(input logic [BYT_W-1:0] b);
      return (b == '0 || b > BYT_W'(4)) ? BYT_W'(4) : b;
   endfunction

endpackage

// File: rtl/zlib_pack_if.sv
// Valid/ready byte-word stream: first byte in dat[31:24], byt valid bytes, lst marks the final word.
interface zlib_pack_if;
   import zlib_pack_pkg::*;

   logic             val;
   logic [31:0]      dat;
   logic [BYT_W-1:0] byt;
   logic             lst;
   logic             rdy;

   modport master (output val, dat, byt, lst, input rdy);
   modport slave  (input val, dat, byt, lst, output rdy);

endinterface

// File: rtl/zlib_byte_align.sv
// Combinational merge of a 0..3-byte residue with 1..4 new bytes into one output word
// plus the bytes left over.
module zlib_byte_align
   import zlib_pack_pkg::*;
(
   input  logic [23:0]      res_dat,
   input  logic [1:0]       res_cnt,
   input  logic [31:0]      new_dat,
   input  logic [BYT_W-1:0] new_cnt,
   output logic [31:0]      word_dat,
   output logic [BYT_W-1:0] word_cnt,
   output logic             word_full,
   output logic [23:0]      rem_dat,
   output logic [1:0]       rem_cnt
);

   logic [23:0]      res_m;
   logic [31:0]      new_m;
   logic [55:0]      cat;
   logic [BYT_W-1:0] sum_cnt;

   // Zero bytes beyond each count so partial words and the residue stay clean.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_res
         assign res_m[23-8*gi -: 8] = (res_cnt > 2'(gi)) ? res_dat[23-8*gi -: 8] : 8'h00;
      end
      for (genvar gi = 0; gi < 4; gi++) begin : g_new
         assign new_m[31-8*gi -: 8] = (new_cnt > BYT_W'(gi)) ? new_dat[31-8*gi -: 8] : 8'h00;
      end
   endgenerate

   assign cat       = {res_m, 32'h0} | ({new_m, 24'h0} >> {res_cnt, 3'b000});
   assign sum_cnt   = {1'b0, res_cnt} + new_cnt;
   assign word_full = (sum_cnt >= BYT_W'(4));
   assign word_dat  = word_full ? cat[55:24] : 32'h0;
   assign word_cnt  = word_full ? BYT_W'(4) : sum_cnt;
   assign rem_dat   = word_full ? cat[23:0] : cat[55:32];
   assign rem_cnt   = sum_cnt[1:0];

endmodule

// File: rtl/zlib_pack.sv
// Wraps a raw DEFLATE word stream into an RFC 1950 zlib stream (header, body, Adler-32 trailer).
// Define ZLIB_PACK_STAT_EN to add the stat_len_o byte counter.
module zlib_pack
   import zlib_pack_pkg::*;
#(
   parameter logic [7:0] ZLIB_CMF = ZLIB_CMF_DEF,
   parameter logic [7:0] ZLIB_FLG = ZLIB_FLG_DEF
)
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        start_i,
   zlib_pack_if.slave  dfl,
   input  logic        adl_done_i,
   input  logic [31:0] adl_dat_i,
   zlib_pack_if.master zo,
   output logic        done_o
`ifdef ZLIB_PACK_STAT_EN
   ,
   output logic [31:0] stat_len_o
`endif
);

   state_t           state_reg;
   logic [23:0]      res_dat_reg;
   logic [1:0]       res_cnt_reg;
   logic [31:0]      adl_reg;
   logic             adl_vld_reg;
   logic [1:0]       tail_step_reg;
   logic             val_reg;
   logic [31:0]      dat_reg;
   logic [BYT_W-1:0] byt_reg;
   logic             lst_reg;
   logic             done_reg;

   logic             out_free;
   logic             dfl_rdy;
   logic             dfl_acc;
   logic             adl_take;
   logic [31:0]      al_new_dat;
   logic [BYT_W-1:0] al_new_cnt;
   logic [31:0]      al_word_dat;
   logic [BYT_W-1:0] al_word_cnt;
   logic             al_full;
   logic [23:0]      al_rem_dat;
   logic [1:0]       al_rem_cnt;

   assign out_free = !val_reg || zo.rdy;
   assign dfl_rdy  = (state_reg == BODY) && out_free;
   assign dfl_acc  = dfl.val && dfl_rdy;
   assign adl_take = adl_done_i && ((state_reg != IDLE) || start_i);

   // One aligner serves both the body merge and the Adler trailer merge.
   assign al_new_dat = (state_reg == TAIL) ? adl_reg : dfl.dat;
   assign al_new_cnt = (state_reg == TAIL) ? BYT_W'(4)
                     : (dfl.lst ? fix_byt(dfl.byt) : BYT_W'(4));

   zlib_byte_align u_align (
      .res_dat   (res_dat_reg),
      .res_cnt   (res_cnt_reg),
      .new_dat   (al_new_dat),
      .new_cnt   (al_new_cnt),
      .word_dat  (al_word_dat),
      .word_cnt  (al_word_cnt),
      .word_full (al_full),
      .rem_dat   (al_rem_dat),
      .rem_cnt   (al_rem_cnt)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg     <= IDLE;
         res_dat_reg   <= '0;
         res_cnt_reg   <= '0;
         adl_reg       <= '0;
         adl_vld_reg   <= 1'b0;
         tail_step_reg <= '0;
         val_reg       <= 1'b0;
         dat_reg       <= '0;
         byt_reg       <= '0;
         lst_reg       <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (val_reg && zo.rdy) begin
            val_reg <= 1'b0;
            lst_reg <= 1'b0;
         end
         if (adl_take) begin
            adl_reg     <= adl_dat_i;
            adl_vld_reg <= 1'b1;
         end
         case (state_reg)
            IDLE: begin
               if (start_i) begin
                  res_dat_reg   <= {ZLIB_CMF, ZLIB_FLG, 8'h00};
                  res_cnt_reg   <= 2'd2;
                  tail_step_reg <= 2'd0;
                  adl_vld_reg   <= adl_done_i;
                  state_reg     <= BODY;
               end
            end
            BODY: begin
               if (dfl_acc) begin
                  res_dat_reg <= al_rem_dat;
                  res_cnt_reg <= al_rem_cnt;
                  if (al_full) begin
                     val_reg <= 1'b1;
                     dat_reg <= al_word_dat;
                     byt_reg <= al_word_cnt;
                     lst_reg <= 1'b0;
                  end
                  // Skip the wait when the checksum is already in hand.
                  if (dfl.lst) begin
                     state_reg <= (adl_vld_reg || adl_done_i) ? TAIL : WAIT_ADL;
                  end
               end
            end
            WAIT_ADL: begin
               if (adl_vld_reg) begin
                  state_reg <= TAIL;
               end
            end
            TAIL: begin
               if (out_free) begin
                  case (tail_step_reg)
                     2'd0: begin
                        val_reg       <= 1'b1;
                        dat_reg       <= al_word_dat;
                        byt_reg       <= al_word_cnt;
                        lst_reg       <= (al_rem_cnt == 2'd0);
                        res_dat_reg   <= al_rem_dat;
                        res_cnt_reg   <= al_rem_cnt;
                        tail_step_reg <= (al_rem_cnt == 2'd0) ? 2'd2 : 2'd1;
                     end
                     2'd1: begin
                        val_reg       <= 1'b1;
                        dat_reg       <= {res_dat_reg, 8'h00};
                        byt_reg       <= {1'b0, res_cnt_reg};
                        lst_reg       <= 1'b1;
                        res_cnt_reg   <= 2'd0;
                        tail_step_reg <= 2'd2;
                     end
                     default: begin
                        // The lst word is handshaking on this edge.
                        done_reg  <= 1'b1;
                        state_reg <= FIN;
                     end
                  endcase
               end
            end
            FIN: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign dfl.rdy = dfl_rdy;
   assign zo.val  = val_reg;
   assign zo.dat  = dat_reg;
   assign zo.byt  = byt_reg;
   assign zo.lst  = lst_reg;
   assign done_o  = done_reg;

`ifdef ZLIB_PACK_STAT_EN
   logic [31:0] stat_len_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_len_reg <= '0;
      end else if (state_reg == IDLE && start_i) begin
         stat_len_reg <= '0;
      end else if (val_reg && zo.rdy) begin
         stat_len_reg <= stat_len_reg + 32'(byt_reg);
      end
   end

   assign stat_len_o = stat_len_reg;
`endif

endmodule
